text_writer: RTL and testbench
==============================

Name: text_writer

Overview:
- Write side of the 256-byte character RAM that the VGA text renderer reads.
- Accepts ASCII characters over a valid/ready handshake and maintains a cursor on the 32-column x 8-row grid, addressed as {row[2:0], col[4:0]}.
- Writes glyph codes into the RAM and handles newline, carriage return, backspace and form feed.
- Asserts ram_busy during full-screen clears so the renderer blanks the display.

Parameters:
- BLANK_CHAR, 8'h20, code written for every cleared cell.
- CLEAR_ON_RESET, 1, if 1 a full-screen clear runs after reset; if 0 go straight to IDLE.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- char_in  input  8  ASCII code offered by the upstream source (e.g. UART RX).
- char_valid  input  1  char_in is valid.
- char_ready  output  1  block can accept; transfer occurs on an edge where valid && ready.
- we  output  1  RAM write enable, one write per high cycle.
- waddr  output  8  RAM write address {row, col}.
- wdata  output  8  RAM write data.
- ram_busy  output  1  high during full-screen clear; the renderer blacks out.
- cursor_row  output  3  current cursor row.
- cursor_col  output  5  current cursor column.

Behaviour:
- Reset and registers: one clock (clk); reset is asynchronous and active-high. All outputs are registered.
- Reset values: we=0, waddr=0, wdata=BLANK_CHAR, cursor=0/0, char_ready=0. With CLEAR_ON_RESET=1: ram_busy=1 and state=CLEAR, clr_cnt=0. With CLEAR_ON_RESET=0: ram_busy=0 and state=IDLE.
- States: IDLE, WRITE, CLEAR, LINECLR.
- IDLE: char_ready=1. On the accepting edge, char_ready<=0 and the action is chosen from char_in:
  - 0x20..0x7E: we<=1, waddr<={row,col}, wdata<=char_in; cursor advances; go to WRITE.
  - 0x0A (LF): col<=0, row<=row+1 (7 wraps to 0); go to LINECLR for the new row.
  - 0x0D (CR): col<=0; go to WRITE with no RAM write.
  - 0x08 (BS): if col>0, col<=col-1. Else if row>0, row<=row-1 and col<=31. Write BLANK_CHAR at the new position; go to WRITE. At 0/0: no write, cursor unchanged.
  - 0x0C (FF): cursor<=0/0, ram_busy<=1, clr_cnt<=0; go to CLEAR.
  - Anything else: ignored; go to WRITE with no RAM write.
- WRITE: lasts exactly 1 cycle. we<=0. If the preceding printable char was written at col 31, col<=0, row<=row+1 (wrap 7->0), and go to LINECLR. Otherwise char_ready<=1 and go to IDLE.
- LINECLR: 32 consecutive edges with we=1, waddr={row, 0..31}, wdata=BLANK_CHAR. The edge after the 32nd write sets we<=0, char_ready<=1, state IDLE. ram_busy stays 0.
- CLEAR: 256 consecutive edges with we=1, waddr=0x00..0xFF, wdata=BLANK_CHAR. The following edge sets we<=0, ram_busy<=0, char_ready<=1, state IDLE.
- Arithmetic: cursor arithmetic is modulo field width; there is no scrolling, and row 7 advancing wraps to row 0.
- Input sampling: char_in is sampled only on the accept edge; changes while char_ready=0 are ignored.
- Reset mid-operation: reset asserted during any state aborts immediately to reset values. A partial LINECLR or CLEAR is not resumed; CLEAR restarts at 0x00 if enabled.
- Throughput: at most one printable char per 2 cycles; LF costs 34 cycles; FF costs 258 cycles.
- No RAM read path: this block only writes.

Test Plan:
- Reset release, CLEAR_ON_RESET=1 -> we high for 256 edges with waddr 0x00..0xFF and wdata=0x20, ram_busy=1 throughout. Then ram_busy=0 and char_ready=1 on edge 257; cursor=0/0.
- Send 'A','B' (0x41,0x42) back-to-back -> writes (0x00,0x41) and (0x01,0x42); char_ready low exactly 1 cycle after each; cursor ends row 0, col 2.
- Send 32 printable chars from 0/0 -> last write at 0x1F; then 32 blank writes at 0x20..0x3F; cursor ends 1/0; char_ready returns after the clear.
- Cursor 7/5, send 0x0A -> cursor 0/0; blank writes to 0x00..0x1F; no write to row 7.
- Cursor 1/0, send 0x08 -> cursor 0/31 with write (0x1F,0x20). At 0/0, send 0x08 -> no we pulse, cursor unchanged.
- Assert reset at the 100th write of a 0x0C clear -> outputs take reset values asynchronously. After release, the clear restarts at waddr 0x00; a 0x07 (BEL) sent afterwards causes no write and char_ready drops for 1 cycle.

Source files
------------

// File: rtl/text_writer.sv
// rtl/text_writer.sv - character RAM write side for the 32x8 VGA text grid
// Accepts ASCII over valid/ready, tracks the cursor, and handles LF/CR/BS/FF and screen clears.
module text_writer #(
    parameter logic [7:0] BLANK_CHAR     = 8'h20,
    parameter bit         CLEAR_ON_RESET = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] char_in,
    input  logic       char_valid,
    output logic       char_ready,
    output logic       we,
    output logic [7:0] waddr,
    output logic [7:0] wdata,
    output logic       ram_busy,
    output logic [2:0] cursor_row,
    output logic [4:0] cursor_col
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WRITE   = 2'd1,
        CLEAR   = 2'd2,
        LINECLR = 2'd3
    } state_t;

    localparam state_t RESET_STATE = CLEAR_ON_RESET ? CLEAR : IDLE;

    localparam logic [7:0] CH_LF = 8'h0A;
    localparam logic [7:0] CH_CR = 8'h0D;
    localparam logic [7:0] CH_BS = 8'h08;
    localparam logic [7:0] CH_FF = 8'h0C;

    state_t     state, state_n;
    logic [8:0] clr_cnt, clr_cnt_n;
    logic       wrap, wrap_n;
    logic       char_ready_n, we_n, ram_busy_n;
    logic [7:0] waddr_n, wdata_n;
    logic [2:0] row_n;
    logic [4:0] col_n;
    logic       accept;
    logic       printable;

    assign accept    = char_valid && char_ready;
    assign printable = (char_in >= 8'h20) && (char_in <= 8'h7E);

    always_comb begin
        state_n      = state;
        clr_cnt_n    = clr_cnt;
        wrap_n       = wrap;
        char_ready_n = char_ready;
        we_n         = 1'b0;
        waddr_n      = waddr;
        wdata_n      = wdata;
        ram_busy_n   = ram_busy;
        row_n        = cursor_row;
        col_n        = cursor_col;

        case (state)
            IDLE: begin
                char_ready_n = 1'b1;
                if (accept) begin
                    char_ready_n = 1'b0;
                    state_n      = WRITE;
                    wrap_n       = 1'b0;
                    if (printable) begin
                        we_n    = 1'b1;
                        waddr_n = {cursor_row, cursor_col};
                        wdata_n = char_in;
                        col_n   = cursor_col + 5'd1;
                        // Row advance is deferred to WRITE so it can kick off the line clear
                        wrap_n  = (cursor_col == 5'd31);
                    end else begin
                        case (char_in)
                            CH_LF: begin
                                col_n     = 5'd0;
                                row_n     = cursor_row + 3'd1;
                                clr_cnt_n = 9'd0;
                                state_n   = LINECLR;
                            end
                            CH_CR: begin
                                col_n = 5'd0;
                            end
                            CH_BS: begin
                                if (cursor_col != 5'd0) begin
                                    col_n   = cursor_col - 5'd1;
                                    we_n    = 1'b1;
                                    waddr_n = {cursor_row, cursor_col - 5'd1};
                                    wdata_n = BLANK_CHAR;
                                end else if (cursor_row != 3'd0) begin
                                    row_n   = cursor_row - 3'd1;
                                    col_n   = 5'd31;
                                    we_n    = 1'b1;
                                    waddr_n = {cursor_row - 3'd1, 5'd31};
                                    wdata_n = BLANK_CHAR;
                                end
                            end
                            CH_FF: begin
                                row_n      = 3'd0;
                                col_n      = 5'd0;
                                ram_busy_n = 1'b1;
                                clr_cnt_n  = 9'd0;
                                state_n    = CLEAR;
                            end
                            default: ;
                        endcase
                    end
                end
            end

            WRITE: begin
                if (wrap) begin
                    col_n     = 5'd0;
                    row_n     = cursor_row + 3'd1;
                    clr_cnt_n = 9'd0;
                    wrap_n    = 1'b0;
                    state_n   = LINECLR;
                end else begin
                    char_ready_n = 1'b1;
                    state_n      = IDLE;
                end
            end

            LINECLR: begin
                if (clr_cnt == 9'd32) begin
                    char_ready_n = 1'b1;
                    state_n      = IDLE;
                end else begin
                    we_n      = 1'b1;
                    waddr_n   = {cursor_row, clr_cnt[4:0]};
                    wdata_n   = BLANK_CHAR;
                    clr_cnt_n = clr_cnt + 9'd1;
                end
            end

            CLEAR: begin
                // Bit 8 marks that all 256 cells have been written
                if (clr_cnt[8]) begin
                    ram_busy_n   = 1'b0;
                    char_ready_n = 1'b1;
                    state_n      = IDLE;
                end else begin
                    we_n      = 1'b1;
                    waddr_n   = clr_cnt[7:0];
                    wdata_n   = BLANK_CHAR;
                    clr_cnt_n = clr_cnt + 9'd1;
                end
            end

            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= RESET_STATE;
            clr_cnt    <= 9'd0;
            wrap       <= 1'b0;
            char_ready <= 1'b0;
            we         <= 1'b0;
            waddr      <= 8'd0;
            wdata      <= BLANK_CHAR;
            ram_busy   <= CLEAR_ON_RESET;
            cursor_row <= 3'd0;
            cursor_col <= 5'd0;
        end else begin
            state      <= state_n;
            clr_cnt    <= clr_cnt_n;
            wrap       <= wrap_n;
            char_ready <= char_ready_n;
            we         <= we_n;
            waddr      <= waddr_n;
            wdata      <= wdata_n;
            ram_busy   <= ram_busy_n;
            cursor_row <= row_n;
            cursor_col <= col_n;
        end
    end

endmodule

// File: tb/tb_text_writer.sv
// tb/tb_text_writer.sv - directed self-checking bench for text_writer
module tb_text_writer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] char_in = 8'h00;
    logic       char_valid = 1'b0;
    logic       char_ready;
    logic       we;
    logic [7:0] waddr;
    logic [7:0] wdata;
    logic       ram_busy;
    logic [2:0] cursor_row;
    logic [4:0] cursor_col;

    int n_checks = 0;
    int n_fail = 0;
    logic [15:0] wlog[$];
    logic busy_seen = 1'b0;

    text_writer #(.BLANK_CHAR(8'h20), .CLEAR_ON_RESET(1'b1)) dut (
        .clk(clk), .reset(reset), .char_in(char_in), .char_valid(char_valid),
        .char_ready(char_ready), .we(we), .waddr(waddr), .wdata(wdata),
        .ram_busy(ram_busy), .cursor_row(cursor_row), .cursor_col(cursor_col)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        if (we) wlog.push_back({waddr, wdata});
        if (ram_busy) busy_seen = 1'b1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] c, output int low);
        int t;
        t = 0;
        while (!char_ready && t < 400) begin @(negedge clk); t++; end
        if (t >= 400) check("ready_timeout", 0, 1);
        char_in = c;
        char_valid = 1'b1;
        @(negedge clk);
        char_valid = 1'b0;
        char_in = 8'h0C;
        low = 0;
        while (!char_ready && low < 400) begin @(negedge clk); low++; end
    endtask

    int k, low, bad;
    logic busy_drop;

    initial begin
        @(negedge clk); @(negedge clk);
        check("rst_we", we, 0);
        check("rst_waddr", waddr, 8'h00);
        check("rst_wdata", wdata, 8'h20);
        check("rst_busy", ram_busy, 1);
        check("rst_ready", char_ready, 0);
        check("rst_cursor", {cursor_row, cursor_col}, 8'h00);

        // Power-up clear
        reset = 1'b0;
        wlog.delete();
        k = 0;
        busy_drop = 1'b0;
        while (!char_ready && k < 400) begin
            @(negedge clk); k++;
            if (k < 257 && !ram_busy) busy_drop = 1'b1;
        end
        check("clr_cycles", k, 257);
        check("clr_busy_held", busy_drop, 0);
        check("clr_busy_end", ram_busy, 0);
        check("clr_nwrites", wlog.size(), 256);
        bad = 0;
        for (int i = 0; i < wlog.size(); i++)
            if (wlog[i] !== {i[7:0], 8'h20}) bad++;
        check("clr_contents", bad, 0);

        // 'A','B'
        wlog.delete();
        send(8'h41, low); check("A_low", low, 1);
        send(8'h42, low); check("B_low", low, 1);
        check("AB_nwrites", wlog.size(), 2);
        if (wlog.size() == 2) begin
            check("A_write", wlog[0], 16'h0041);
            check("B_write", wlog[1], 16'h0142);
        end
        check("AB_cursor", {cursor_row, cursor_col}, {3'd0, 5'd2});

        // CR then 32 printable chars: wrap triggers a clear of row 1
        send(8'h0D, low); check("CR_low", low, 1);
        check("CR_cursor", {cursor_row, cursor_col}, 8'h00);
        wlog.delete();
        bad = 0;
        for (int i = 0; i < 32; i++) begin
            send(8'h41 + i[7:0], low);
            if (i < 31 && low != 1) bad++;
        end
        check("row_low_chars", bad, 0);
        check("row_wrap_low", low, 34);
        check("row_nwrites", wlog.size(), 64);
        bad = 0;
        for (int i = 0; i < wlog.size(); i++) begin
            if (i < 32 && wlog[i] !== {i[7:0], 8'h41 + i[7:0]}) bad++;
            if (i >= 32 && wlog[i] !== {i[7:0], 8'h20}) bad++;
        end
        check("row_contents", bad, 0);
        check("row_cursor", {cursor_row, cursor_col}, {3'd1, 5'd0});

        // Move to 7/5 then LF wraps to row 0
        for (int i = 0; i < 6; i++) send(8'h0A, low);
        for (int i = 0; i < 5; i++) send(8'h78, low);
        check("pre_lf_cursor", {cursor_row, cursor_col}, {3'd7, 5'd5});
        wlog.delete();
        busy_seen = 1'b0;
        send(8'h0A, low);
        check("lf_low", low, 33);
        check("lf_cursor", {cursor_row, cursor_col}, 8'h00);
        check("lf_nwrites", wlog.size(), 32);
        bad = 0;
        for (int i = 0; i < wlog.size(); i++)
            if (wlog[i] !== {i[7:0], 8'h20}) bad++;
        check("lf_contents", bad, 0);
        check("lf_no_busy", busy_seen, 0);

        // Backspace across a row boundary, then at 0/0
        send(8'h0A, low);
        check("bs_pre_cursor", {cursor_row, cursor_col}, {3'd1, 5'd0});
        wlog.delete();
        send(8'h08, low);
        check("bs_cursor", {cursor_row, cursor_col}, {3'd0, 5'd31});
        check("bs_nwrites", wlog.size(), 1);
        if (wlog.size() == 1) check("bs_write", wlog[0], 16'h1F20);
        send(8'h0D, low);
        wlog.delete();
        send(8'h08, low);
        check("bs00_low", low, 1);
        check("bs00_nwrites", wlog.size(), 0);
        check("bs00_cursor", {cursor_row, cursor_col}, 8'h00);

        // Form feed aborted by reset at the 100th write
        send(8'h41, low);
        wlog.delete();
        k = 0;
        while (!char_ready && k < 400) begin @(negedge clk); k++; end
        char_in = 8'h0C; char_valid = 1'b1;
        @(negedge clk);
        char_valid = 1'b0;
        check("ff_busy", ram_busy, 1);
        check("ff_cursor", {cursor_row, cursor_col}, 8'h00);
        k = 0;
        while (wlog.size() < 100 && k < 400) begin @(negedge clk); k++; end
        check("ff_reach100", wlog.size(), 100);
        check("ff_we_at100", we, 1);
        #2 reset = 1'b1;
        #1;
        check("arst_we", we, 0);
        check("arst_waddr", waddr, 8'h00);
        check("arst_wdata", wdata, 8'h20);
        check("arst_busy", ram_busy, 1);
        check("arst_ready", char_ready, 0);
        @(negedge clk); @(negedge clk);
        reset = 1'b0;
        wlog.delete();
        k = 0;
        while (!char_ready && k < 400) begin @(negedge clk); k++; end
        check("reclr_cycles", k, 257);
        check("reclr_nwrites", wlog.size(), 256);
        if (wlog.size() == 256) begin
            check("reclr_first", wlog[0], 16'h0020);
            check("reclr_last", wlog[255], 16'hFF20);
        end

        // BEL is ignored
        wlog.delete();
        send(8'h07, low);
        check("bel_low", low, 1);
        check("bel_nwrites", wlog.size(), 0);
        check("bel_cursor", {cursor_row, cursor_col}, 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
